// File: rtl/bram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module   : bram_march_bist
//  Purpose  : March C- built-in self-test and initialisation sequencer for one
//             port of a 9-bit (8 data + 1 parity) single-clock BRAM with a
//             1-cycle registered read. It runs the full March C- over the
//             address space, compares every read, and captures the first
//             failure. A passing run leaves every word at {0, BG_PATTERN}.
//  Revision : 1.0  initial release
//
//  Ports
//    clk            rising-edge clock
//    rst_n          asynchronous active-low reset
//    start_i        one-cycle run request, accepted in IDLE or DONE only
//    busy_o         run in progress
//    done_o         run finished (level, held until the next accepted start)
//    fail_o         sticky: at least one miscompare in this run
//    fail_addr_o    address of the first miscompare
//    fail_elem_o    march element (1..5) of the first miscompare
//    fail_data_o    {dop,do} captured at the first miscompare
//    fail_cnt_o     miscompare count, saturating at 255
//    bram_addr_o    BRAM address
//    bram_en_o      BRAM enable
//    bram_we_o      BRAM write enable
//    bram_ssr_o     BRAM output sync reset (tied 0)
//    bram_di_o      BRAM write data
//    bram_dip_o     BRAM write parity
//    bram_do_i      BRAM read data (valid the cycle after a read)
//    bram_dop_i     BRAM read parity (same timing as bram_do_i)
//
//  Build option
//    BRAM_MARCH_BIST_PARITY_EN : when defined the parity bit carries the
//    pattern bit and takes part in the compare; otherwise bram_dip_o is 0
//    and bram_dop_i is only captured, never compared.
// ============================================================================
module bram_march_bist #(
    parameter int          ADDR_W     = 11,
    parameter logic [7:0]  BG_PATTERN = 8'h00
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              fail_o,
    output logic [ADDR_W-1:0] fail_addr_o,
    output logic [2:0]        fail_elem_o,
    output logic [8:0]        fail_data_o,
    output logic [7:0]        fail_cnt_o,
    output logic [ADDR_W-1:0] bram_addr_o,
    output logic              bram_en_o,
    output logic              bram_we_o,
    output logic              bram_ssr_o,
    output logic [7:0]        bram_di_o,
    output logic              bram_dip_o,
    input  logic [7:0]        bram_do_i,
    input  logic              bram_dop_i
);

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_M0    = 4'd1,
        S_M1    = 4'd2,
        S_M2    = 4'd3,
        S_M3    = 4'd4,
        S_M4    = 4'd5,
        S_M5    = 4'd6,
        S_FLUSH = 4'd7,
        S_DONE  = 4'd8
    } state_t;

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

`ifdef BRAM_MARCH_BIST_PARITY_EN
    localparam logic [8:0] CMP_MASK = 9'h1FF;
`else
    localparam logic [8:0] CMP_MASK = 9'h0FF;
`endif

    // Sequencer position: element, address and read/write phase.
    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;

    // Registered BRAM controls.
    logic              en_q, we_q, dip_q;
    logic [7:0]        di_q;
    logic              en_d, we_d, dip_d, one_d;
    logic [7:0]        di_d;

    // Compare pipeline: expectation registered alongside each read.
    logic              cmp_vld_q;
    logic [8:0]        cmp_exp_q;
    logic [ADDR_W-1:0] cmp_addr_q;
    logic [2:0]        cmp_elem_q;

    logic              busy_q, done_q, fail_q;
    logic [ADDR_W-1:0] fail_addr_q;
    logic [2:0]        fail_elem_q;
    logic [8:0]        fail_data_q;
    logic [7:0]        fail_cnt_q;

    logic              start_ok;
    logic [8:0]        rd_word;
    logic              miscmp;

    function automatic logic [2:0] elem_of(input state_t s);
        case (s)
            S_M1:    elem_of = 3'd1;
            S_M2:    elem_of = 3'd2;
            S_M3:    elem_of = 3'd3;
            S_M4:    elem_of = 3'd4;
            S_M5:    elem_of = 3'd5;
            default: elem_of = 3'd0;
        endcase
    endfunction

    assign start_ok = ((state_q == S_IDLE) || (state_q == S_DONE)) && start_i;
    assign rd_word  = {bram_dop_i, bram_do_i};
    assign miscmp   = cmp_vld_q && (((rd_word ^ cmp_exp_q) & CMP_MASK) != 9'd0);

    // Next position in the march. Address only wraps at element boundaries,
    // where it is reloaded with the start address of the next element.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start_i) begin
                    state_d = S_M0;
                    addr_d  = '0;
                    phase_d = 1'b0;
                end
            end
            S_M0: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_M1;
                    addr_d  = '0;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_M1, S_M2: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == ADDR_MAX) begin
                        state_d = (state_q == S_M1) ? S_M2 : S_M3;
                        addr_d  = (state_q == S_M1) ? '0 : ADDR_MAX;
                    end else begin
                        addr_d = addr_q + ADDR_ONE;
                    end
                end
            end
            S_M3, S_M4: begin
                if (!phase_q) begin
                    phase_d = 1'b1;
                end else begin
                    phase_d = 1'b0;
                    if (addr_q == '0) begin
                        state_d = (state_q == S_M3) ? S_M4 : S_M5;
                        addr_d  = (state_q == S_M3) ? ADDR_MAX : '0;
                    end else begin
                        addr_d = addr_q - ADDR_ONE;
                    end
                end
            end
            S_M5: begin
                if (addr_q == ADDR_MAX) begin
                    state_d = S_FLUSH;
                end else begin
                    addr_d = addr_q + ADDR_ONE;
                end
            end
            S_FLUSH: state_d = S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // BRAM operation for the next position. In M1/M3 the pattern bit equals
    // the phase (r0 then w1); in M2/M4 it is inverted (r1 then w0). During a
    // read the data bus carries the expected word so it can be registered
    // into the compare pipeline.
    always_comb begin
        en_d  = state_d inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5};
        we_d  = (state_d == S_M0) ||
                ((state_d inside {S_M1, S_M2, S_M3, S_M4}) && phase_d);
        one_d = 1'b0;
        if (state_d inside {S_M1, S_M3}) begin
            one_d = phase_d;
        end else if (state_d inside {S_M2, S_M4}) begin
            one_d = !phase_d;
        end
        di_d = one_d ? ~BG_PATTERN : BG_PATTERN;
`ifdef BRAM_MARCH_BIST_PARITY_EN
        dip_d = one_d;
`else
        dip_d = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            phase_q     <= 1'b0;
            en_q        <= 1'b0;
            we_q        <= 1'b0;
            di_q        <= 8'd0;
            dip_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            cmp_vld_q   <= 1'b0;
            cmp_exp_q   <= 9'd0;
            cmp_addr_q  <= '0;
            cmp_elem_q  <= 3'd0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= 3'd0;
            fail_data_q <= 9'd0;
            fail_cnt_q  <= 8'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            en_q    <= en_d;
            we_q    <= we_d;
            if (en_d) begin
                di_q  <= di_d;
                dip_q <= dip_d;
            end
            busy_q <= state_d inside {S_M0, S_M1, S_M2, S_M3, S_M4, S_M5, S_FLUSH};
            done_q <= (state_d == S_DONE);

            cmp_vld_q <= en_q && !we_q;
            if (en_q && !we_q) begin
                cmp_exp_q  <= {dip_q, di_q};
                cmp_addr_q <= addr_q;
                cmp_elem_q <= elem_of(state_q);
            end

            if (start_ok) begin
                fail_q      <= 1'b0;
                fail_addr_q <= '0;
                fail_elem_q <= 3'd0;
                fail_data_q <= 9'd0;
                fail_cnt_q  <= 8'd0;
            end else if (miscmp) begin
                fail_q <= 1'b1;
                if (fail_cnt_q != 8'hFF) begin
                    fail_cnt_q <= fail_cnt_q + 8'd1;
                end
                // Only the first miscompare of a run is recorded.
                if (!fail_q) begin
                    fail_addr_q <= cmp_addr_q;
                    fail_elem_q <= cmp_elem_q;
                    fail_data_q <= rd_word;
                end
            end
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign fail_o      = fail_q;
    assign fail_addr_o = fail_addr_q;
    assign fail_elem_o = fail_elem_q;
    assign fail_data_o = fail_data_q;
    assign fail_cnt_o  = fail_cnt_q;
    assign bram_addr_o = addr_q;
    assign bram_en_o   = en_q;
    assign bram_we_o   = we_q;
    assign bram_ssr_o  = 1'b0;
    assign bram_di_o   = di_q;
    assign bram_dip_o  = dip_q;

endmodule
`default_nettype wire

// File: tb/tb_bram_march_bist.sv
`default_nettype none
// ============================================================================
//  Module   : tb_bram_march_bist
//  Purpose  : Self-checking bench for bram_march_bist (ADDR_W=4). A BRAM model
//             with a single programmable stuck-at cell sits on the port; a
//             March C- model derived from the element list predicts the full
//             operation sequence and the fail summary of each run.
//  Revision : 1.0  initial release
//  Build option: honours BRAM_MARCH_BIST_PARITY_EN like the design.
// ============================================================================
module tb_bram_march_bist;

    localparam int         AW    = 4;
    localparam int         DEPTH = 16;
    localparam logic [7:0] BG    = 8'h00;
`ifdef BRAM_MARCH_BIST_PARITY_EN
    localparam logic       PAR1  = 1'b1;
    localparam logic [8:0] MASK  = 9'h1FF;
`else
    localparam logic       PAR1  = 1'b0;
    localparam logic [8:0] MASK  = 9'h0FF;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          busy, done, fail;
    logic [AW-1:0] fail_addr;
    logic [2:0]    fail_elem;
    logic [8:0]    fail_data;
    logic [7:0]    fail_cnt;
    logic [AW-1:0] bram_addr;
    logic          bram_en, bram_we, bram_ssr, bram_dip;
    logic [7:0]    bram_di;
    logic [7:0]    bram_do;
    logic          bram_dop;

    int n_chk  = 0;
    int n_fail = 0;
    int busy_cycles = 0;

    always #5 clk = ~clk;

    bram_march_bist #(.ADDR_W(AW), .BG_PATTERN(BG)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start),
        .busy_o(busy), .done_o(done), .fail_o(fail),
        .fail_addr_o(fail_addr), .fail_elem_o(fail_elem),
        .fail_data_o(fail_data), .fail_cnt_o(fail_cnt),
        .bram_addr_o(bram_addr), .bram_en_o(bram_en), .bram_we_o(bram_we),
        .bram_ssr_o(bram_ssr), .bram_di_o(bram_di), .bram_dip_o(bram_dip),
        .bram_do_i(bram_do), .bram_dop_i(bram_dop)
    );

    // ---------------- BRAM model with one stuck-at cell --------------------
    logic          fault_on = 1'b0;
    logic [AW-1:0] fault_addr = '0;
    logic [8:0]    sa0_mask = '0, sa1_mask = '0;
    logic [8:0]    mem_b [DEPTH];
    logic [8:0]    dout_q = '0;

    function automatic logic [8:0] apply_fault(input logic [AW-1:0] a, input logic [8:0] v);
        if (fault_on && a == fault_addr) return (v & ~sa0_mask) | sa1_mask;
        return v;
    endfunction

    always @(posedge clk) begin
        if (bram_en) begin
            if (bram_we) begin
                mem_b[bram_addr] <= apply_fault(bram_addr, {bram_dip, bram_di});
                dout_q           <= apply_fault(bram_addr, {bram_dip, bram_di});
            end else begin
                dout_q <= mem_b[bram_addr];
            end
        end
    end
    assign {bram_dop, bram_do} = dout_q;

    // ---------------- March C- reference model -----------------------------
    typedef struct {
        bit            en;
        bit            we;
        logic [AW-1:0] addr;
        logic [8:0]    wd;
    } op_t;

    op_t exp_ops[$];
    logic          m_fail;
    logic [AW-1:0] m_addr;
    logic [2:0]    m_elem;
    logic [8:0]    m_data;
    int            m_cnt;

    function automatic logic [8:0] pat(input bit one);
        return one ? {PAR1, ~BG} : {1'b0, BG};
    endfunction

    task automatic build_model();
        logic [8:0]    mm [DEPTH];
        logic [AW-1:0] a;
        bit            rv;
        op_t           op;
        exp_ops.delete();
        m_fail = 1'b0; m_addr = '0; m_elem = '0; m_data = '0; m_cnt = 0;
        for (int i = 0; i < DEPTH; i++) mm[i] = '0;
        for (int e = 0; e < 6; e++) begin
            for (int k = 0; k < DEPTH; k++) begin
                a  = AW'((e == 3 || e == 4) ? DEPTH - 1 - k : k);
                rv = (e == 2 || e == 4);
                if (e != 0) begin
                    op = '{en: 1'b1, we: 1'b0, addr: a, wd: '0};
                    exp_ops.push_back(op);
                    if (((mm[a] ^ pat(rv)) & MASK) != 9'd0) begin
                        if (!m_fail) begin
                            m_addr = a; m_elem = 3'(e); m_data = mm[a];
                        end
                        m_fail = 1'b1;
                        if (m_cnt < 255) m_cnt++;
                    end
                end
                if (e != 5) begin
                    op = '{en: 1'b1, we: 1'b1, addr: a, wd: pat(e == 0 ? 1'b0 : !rv)};
                    exp_ops.push_back(op);
                    mm[a] = apply_fault(a, op.wd);
                end
            end
        end
        op = '{en: 1'b0, we: 1'b0, addr: '0, wd: '0};
        exp_ops.push_back(op);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- Per-cycle compare process ----------------------------
    always @(negedge clk) begin
        op_t op;
        if (rst_n === 1'b1) begin
            n_chk++;
            if (bram_ssr !== 1'b0) begin
                n_fail++;
                $display("FAIL ssr: got %b expected 0", bram_ssr);
            end
            if (busy === 1'b1) begin
                busy_cycles++;
                n_chk++;
                if (exp_ops.size() == 0) begin
                    n_fail++;
                    $display("FAIL op_seq: busy beyond expected sequence at cycle %0d", busy_cycles);
                end else begin
                    op = exp_ops.pop_front();
                    if (bram_en !== op.en || bram_we !== op.we ||
                        (op.en && bram_addr !== op.addr) ||
                        (op.we && {bram_dip, bram_di} !== op.wd)) begin
                        n_fail++;
                        $display("FAIL op_seq cyc %0d: got en=%b we=%b addr=%0h d=%0h expected en=%b we=%b addr=%0h d=%0h",
                                 busy_cycles, bram_en, bram_we, bram_addr, {bram_dip, bram_di},
                                 op.en, op.we, op.addr, op.wd);
                    end
                end
            end else if (bram_en !== 1'b0) begin
                n_chk++;
                n_fail++;
                $display("FAIL idle_en: got %b expected 0", bram_en);
            end
        end
    end

    // ---------------- Run task ---------------------------------------------
    task automatic do_run(input int extra_start_at, input bit check_mem);
        build_model();
        busy_cycles = 0;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk("start_busy", 32'(busy), 32'd1);
        chk("start_done_clr", 32'(done), 32'd0);
        chk("start_fail_clr", 32'(fail), 32'd0);
        chk("start_cnt_clr", 32'(fail_cnt), 32'd0);
        for (int i = 0; i < 400 && done !== 1'b1; i++) begin
            @(negedge clk);
            start = (i == extra_start_at) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        chk("done_reached", 32'(done), 32'd1);
        chk("busy_len", 32'(busy_cycles), 32'(10 * DEPTH + 1));
        chk("ops_left", 32'(exp_ops.size()), 32'd0);
        chk("fail_flag", 32'(fail), 32'(m_fail));
        chk("fail_cnt", 32'(fail_cnt), 32'(m_cnt));
        if (m_fail) begin
            chk("fail_addr", 32'(fail_addr), 32'(m_addr));
            chk("fail_elem", 32'(fail_elem), 32'(m_elem));
            chk("fail_data", 32'(fail_data), 32'(m_data));
        end
        if (check_mem) begin
            for (int a = 0; a < DEPTH; a++)
                chk("final_mem", 32'(mem_b[a]), 32'({1'b0, BG}));
        end
    endtask

    initial begin
        #2_000_000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(negedge clk);
        // Reset state
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_fail", 32'(fail), 32'd0);
        chk("rst_en_we", 32'({bram_en, bram_we, bram_ssr}), 32'd0);
        chk("rst_regs", 32'({fail_addr, fail_elem, fail_data, fail_cnt}), 32'd0);
        chk("rst_bus", 32'({bram_addr, bram_di, bram_dip}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Clean pass
        do_run(-1, 1'b1);

        // Bit 3 of address 5 stuck-at-1
        fault_on = 1'b1; fault_addr = 4'h5; sa0_mask = '0; sa1_mask = 9'h008;
        do_run(-1, 1'b0);
        chk("pin_model_cnt", 32'(m_cnt), 32'd3);
        chk("pin_model_addr", 32'(m_addr), 32'h5);
        chk("sa1_fail", 32'(fail), 32'd1);
        chk("sa1_addr", 32'(fail_addr), 32'h5);
        chk("sa1_elem", 32'(fail_elem), 32'd1);
        chk("sa1_data", 32'(fail_data[7:0]), 32'h08);
        chk("sa1_cnt", 32'(fail_cnt), 32'd3);

        // Clean run right after a failing one: start must clear fail state
        fault_on = 1'b0;
        do_run(-1, 1'b1);

        // Parity of address 0xF stuck-at-0
        fault_on = 1'b1; fault_addr = 4'hF; sa0_mask = 9'h100; sa1_mask = '0;
        do_run(-1, 1'b0);
`ifdef BRAM_MARCH_BIST_PARITY_EN
        chk("par_fail", 32'(fail), 32'd1);
        chk("par_addr", 32'(fail_addr), 32'hF);
        chk("par_elem", 32'(fail_elem), 32'd2);
        chk("par_data", 32'(fail_data), 32'h0FF);
        chk("par_cnt", 32'(fail_cnt), 32'd2);
`else
        chk("par_fail", 32'(fail), 32'd0);
        chk("par_cnt", 32'(fail_cnt), 32'd0);
`endif

        // start pulsed 20 cycles into a run is ignored
        fault_on = 1'b0;
        do_run(18, 1'b1);

        // Asynchronous reset mid-run
        build_model();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        repeat (49) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_en_we", 32'({bram_en, bram_we}), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        exp_ops.delete();
        repeat (2) @(negedge clk);
        chk("post_rst_idle", 32'({busy, done, bram_en}), 32'd0);
        do_run(-1, 1'b1);

        // Randomized single stuck-at faults and stray start pulses
        for (int r = 0; r < 8; r++) begin
            int b;
            fault_on   = 1'b1;
            fault_addr = AW'($urandom_range(0, DEPTH - 1));
            b          = int'($urandom_range(0, 8));
            if ($urandom_range(0, 1) == 1) begin
                sa1_mask = 9'(1 << b); sa0_mask = '0;
            end else begin
                sa0_mask = 9'(1 << b); sa1_mask = '0;
            end
            do_run(($urandom_range(0, 1) == 1) ? int'($urandom_range(0, 150)) : -1, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
